// File: rtl/addr_bus_mux.sv
// addr_bus_mux: snapshots the 16-bit CPU address and ships it to the expansion CPLD as two bytes, high then low.
// Latency: HI0 one cycle after the trigger, frame_done 4*HALF_CYCLES+1 cycles after it; the link has no backpressure.
// Define ADDR_MUX_CHANGE_ONLY_EN to send only on address change or flush; the default build runs frames back-to-back.
module addr_bus_mux #(
  parameter int unsigned HALF_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic        flush,
  output logic [7:0]  mux_a,
  output logic        clkmux,
  output logic        selectmux,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] sent_a
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI0  = 3'd1,
    HI1  = 3'd2,
    LO0  = 3'd3,
    LO1  = 3'd4
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(HALF_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] snap;
  logic        phase_end;
  logic        start;
  logic        enter_hi0;

  assign phase_end = (cnt == CNT_LAST);

`ifdef ADDR_MUX_CHANGE_ONLY_EN
  logic pend;

  assign start     = (cpu_a != sent_a) || flush || pend;
  assign enter_hi0 = (state == IDLE) && start;

  // A flush seen mid-frame is replayed as one extra frame once the FSM is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (enter_hi0) begin
      pend <= 1'b0;
    end else if (flush && busy) begin
      pend <= 1'b1;
    end
  end
`else
  logic unused_flush;

  assign unused_flush = flush;
  assign start        = 1'b1;
  assign enter_hi0    = ((state == IDLE) && start) || ((state == LO1) && phase_end);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      snap       <= '0;
      mux_a      <= 8'h00;
      clkmux     <= 1'b0;
      selectmux  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sent_a     <= 16'h0000;
    end else begin
      frame_done <= 1'b0;

      if (enter_hi0) begin
        // Both bytes of the frame come from this single sample.
        state     <= HI0;
        cnt       <= '0;
        snap      <= cpu_a;
        mux_a     <= cpu_a[15:8];
        selectmux <= 1'b1;
        clkmux    <= 1'b0;
        busy      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            cnt    <= '0;
            clkmux <= 1'b0;
          end
          HI0: begin
            if (phase_end) begin
              state  <= HI1;
              cnt    <= '0;
              clkmux <= 1'b1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          HI1: begin
            if (phase_end) begin
              state     <= LO0;
              cnt       <= '0;
              clkmux    <= 1'b0;
              selectmux <= 1'b0;
              mux_a     <= snap[7:0];
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          LO0: begin
            if (phase_end) begin
              state  <= LO1;
              cnt    <= '0;
              clkmux <= 1'b1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          LO1: begin
            if (phase_end) begin
              state  <= IDLE;
              cnt    <= '0;
              clkmux <= 1'b0;
              busy   <= 1'b0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          default: begin
            state  <= IDLE;
            cnt    <= '0;
            clkmux <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end

      // The low-byte strobe has gone out: the CPLD now holds the full address.
      if ((state == LO1) && phase_end) begin
        sent_a     <= snap;
        frame_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_addr_bus_mux.sv
// Bench for addr_bus_mux: two instances (HALF_CYCLES 1 and 3) against a frame-position reference model.
module tb_addr_bus_mux;

`ifdef ADDR_MUX_CHANGE_ONLY_EN
  localparam bit CO = 1'b1;
`else
  localparam bit CO = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  mux;
    logic        sel;
    logic        clk;
    logic        busy;
    logic        fd;
    logic [15:0] sent;
  } obs_t;

  typedef struct packed {
    bit          active;
    int          start;
    logic [15:0] snap;
    logic [15:0] sent;
    bit          pend;
    obs_t        o;
  } mdl_t;

  typedef struct packed {
    logic [15:0] a;
    obs_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_a;
  logic        flush;

  logic [7:0]  mux_a_1, mux_a_3;
  logic        clkmux_1, clkmux_3, selectmux_1, selectmux_3;
  logic        busy_1, busy_3, frame_done_1, frame_done_3;
  logic [15:0] sent_a_1, sent_a_3;
  obs_t        o1, o3;

  int   checks = 0;
  int   errors = 0;
  int   n = 0;
  mdl_t m1, m3;
  vec_t tbl[$];

  logic [15:0] ra;
  logic        rf;
  int          k, fd_cnt, rise_cnt;
  bit          found;
  logic        prev_clk;

  always #5 clk = ~clk;

  addr_bus_mux #(.HALF_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .cpu_a(cpu_a), .flush(flush),
    .mux_a(mux_a_1), .clkmux(clkmux_1), .selectmux(selectmux_1),
    .busy(busy_1), .frame_done(frame_done_1), .sent_a(sent_a_1)
  );

  addr_bus_mux #(.HALF_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .cpu_a(cpu_a), .flush(flush),
    .mux_a(mux_a_3), .clkmux(clkmux_3), .selectmux(selectmux_3),
    .busy(busy_3), .frame_done(frame_done_3), .sent_a(sent_a_3)
  );

  assign o1.mux  = mux_a_1;
  assign o1.sel  = selectmux_1;
  assign o1.clk  = clkmux_1;
  assign o1.busy = busy_1;
  assign o1.fd   = frame_done_1;
  assign o1.sent = sent_a_1;
  assign o3.mux  = mux_a_3;
  assign o3.sel  = selectmux_3;
  assign o3.clk  = clkmux_3;
  assign o3.busy = busy_3;
  assign o3.fd   = frame_done_3;
  assign o3.sent = sent_a_3;

  // Reference: a frame is a start edge plus a position; outputs follow from the position alone.
  function automatic mdl_t model_step(input mdl_t m, input int h, input logic [15:0] a,
                                      input logic f, input int edge_n);
    mdl_t r;
    bit   was_busy;
    int   p;
    r        = m;
    was_busy = m.active;
    r.o.fd   = 1'b0;
    if (m.active && (edge_n - m.start) == 4 * h) begin
      r.sent   = m.snap;
      r.o.fd   = 1'b1;
      r.active = 1'b0;
      if (!CO) begin
        r.active = 1'b1;
        r.start  = edge_n;
        r.snap   = a;
      end
    end
    if (!was_busy && (!CO || a != m.sent || f || m.pend)) begin
      r.active = 1'b1;
      r.start  = edge_n;
      r.snap   = a;
      r.pend   = 1'b0;
    end
    if (CO && was_busy && f) r.pend = 1'b1;
    if (r.active) begin
      p       = edge_n - r.start;
      r.o.sel = (p < 2 * h);
      r.o.clk = ((p / h) % 2) == 1;
      r.o.mux = r.o.sel ? r.snap[15:8] : r.snap[7:0];
    end else begin
      r.o.clk = 1'b0;
    end
    r.o.busy = r.active;
    r.o.sent = r.sent;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h, required %h (cycle %0d)", name, act, req, n);
    end
  endtask

  task automatic cmp(input string tag, input obs_t act, input obs_t req);
    chk({tag, ".mux_a"},      16'(act.mux),  16'(req.mux));
    chk({tag, ".selectmux"},  16'(act.sel),  16'(req.sel));
    chk({tag, ".clkmux"},     16'(act.clk),  16'(req.clk));
    chk({tag, ".busy"},       16'(act.busy), 16'(req.busy));
    chk({tag, ".frame_done"}, 16'(act.fd),   16'(req.fd));
    chk({tag, ".sent_a"},     act.sent,      req.sent);
  endtask

  task automatic tick(input logic [15:0] a, input logic f);
    cpu_a = a;
    flush = f;
    @(posedge clk);
    #1;
    n++;
    m1 = model_step(m1, 1, a, f, n);
    m3 = model_step(m3, 3, a, f, n);
    flush = 1'b0;
  endtask

  task automatic tick_cmp(input string tag, input logic [15:0] a, input logic f);
    tick(a, f);
    cmp({tag, "_h1"}, o1, m1.o);
    cmp({tag, "_h3"}, o3, m3.o);
  endtask

  task automatic do_reset(input logic [15:0] a);
    cpu_a = a;
    flush = 1'b0;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n   = 0;
    m1  = '0;
    m3  = '0;
    cmp("reset_h1", o1, '0);
    cmp("reset_h3", o3, '0);
  endtask

  initial begin
    rst   = 1'b1;
    cpu_a = 16'h0000;
    flush = 1'b0;

    // Vector table for the HALF_CYCLES=1 instance, one record per clock edge after reset.
`ifdef ADDR_MUX_CHANGE_ONLY_EN
    tbl.push_back('{16'h0000, '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}});
    tbl.push_back('{16'h0000, '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}});
    tbl.push_back('{16'h0000, '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}});
    tbl.push_back('{16'h4000, '{8'h40, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000}});
    tbl.push_back('{16'h4000, '{8'h40, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000}});
    tbl.push_back('{16'h4000, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000}});
    tbl.push_back('{16'h4000, '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000}});
    tbl.push_back('{16'h4000, '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4000}});
    tbl.push_back('{16'h4000, '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4000}});
    tbl.push_back('{16'h4000, '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4000}});
    do_reset(16'h0000);
`else
    tbl.push_back('{16'hA55A, '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000}});
    tbl.push_back('{16'hA55A, '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000}});
    tbl.push_back('{16'hA55A, '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000}});
    tbl.push_back('{16'hA55A, '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000}});
    tbl.push_back('{16'hA55A, '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 16'hA55A}});
    tbl.push_back('{16'hA55A, '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 16'hA55A}});
    tbl.push_back('{16'hA55A, '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA55A}});
    tbl.push_back('{16'hA55A, '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 16'hA55A}});
    tbl.push_back('{16'hA55A, '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 16'hA55A}});
    do_reset(16'hA55A);
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].a, 1'b0);
      cmp($sformatf("vec%0d", i), o1, tbl[i].e);
      cmp($sformatf("vec%0d_h3", i), o3, m3.o);
    end

`ifdef ADDR_MUX_CHANGE_ONLY_EN
    // Flush during LO0: current frame finishes, one identical frame follows, then IDLE.
    do_reset(16'h0000);
    fd_cnt   = 0;
    rise_cnt = 0;
    prev_clk = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick_cmp("flush_seq", 16'h2222, (i == 3));
      if (i == 5) chk("flush_refire_mux", 16'(mux_a_1), 16'h0022);
      if (frame_done_1) fd_cnt++;
      if (clkmux_1 && !prev_clk) rise_cnt++;
      prev_clk = clkmux_1;
    end
    chk("flush_frames", 16'(fd_cnt), 16'd2);
    chk("flush_strobes", 16'(rise_cnt), 16'd4);
    chk("flush_idle_busy", 16'(busy_1), 16'd0);
    chk("flush_sent", sent_a_1, 16'h2222);
`else
    // Coherency: cpu_a moves during HI1, the frame in flight keeps its sample.
    do_reset(16'h1234);
    tick_cmp("coh", 16'h1234, 1'b0);
    tick_cmp("coh", 16'h1234, 1'b0);
    chk("coh_hi1_mux", 16'(mux_a_1), 16'h0012);
    tick_cmp("coh", 16'hFFFF, 1'b0);
    chk("coh_lo0_mux", 16'(mux_a_1), 16'h0034);
    tick_cmp("coh", 16'hFFFF, 1'b0);
    chk("coh_lo1_mux", 16'(mux_a_1), 16'h0034);
    tick_cmp("coh", 16'hFFFF, 1'b0);
    chk("coh_sent", sent_a_1, 16'h1234);
    chk("coh_next_hi", 16'(mux_a_1), 16'h00FF);
    tick_cmp("coh", 16'hFFFF, 1'b0);
    tick_cmp("coh", 16'hFFFF, 1'b0);
    chk("coh_next_lo", 16'(mux_a_1), 16'h00FF);
`endif

    // Reset asserted in LO0 after a completed frame clears the outputs at once.
    do_reset(16'hBEEF);
    k     = 0;
    found = 1'b0;
    while (!found && k < 50) begin
      tick_cmp("pre_rst", (n < 6) ? 16'hBEEF : 16'h1111, 1'b0);
      k++;
      found = busy_1 && !selectmux_1 && !clkmux_1 && (sent_a_1 != 16'h0000);
    end
    chk("reach_lo0", 16'(found), 16'd1);
    rst = 1'b1;
    #1;
    cmp("midframe_rst_h1", o1, '0);
    cmp("midframe_rst_h3", o3, '0);

    // Randomized traffic after reset release, both instances against the model.
    do_reset(16'h3C5A);
    ra = 16'h3C5A;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) ra = 16'($urandom);
      rf = ($urandom_range(0, 15) == 0);
      tick_cmp("rand", ra, rf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_bus_mux.md
# addr_bus_mux

FPGA-side serialiser that drives the 8-bit multiplexed address link to the expansion-bus CPLD. It snapshots the 16-bit CPU address and sends it as two bytes, high then low, qualified by `selectmux` and strobed by rising edges of `clkmux`. After the second strobe the CPLD presents the full 16-bit address on the expansion connector. The block sits in the ZX-Uno core between the CPU address bus and the CPLD pins `zxuno_a`, `clkmux` and `selectmux`.

## Interface
- `HALF_CYCLES`, default 1: `clk` cycles per `clkmux` half-period; legal range 1..15.
- `clk`  in  1  core clock, e.g. 28 MHz; every register uses its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_a`  in  16  CPU address; sampled only at snapshot.
- `flush`  in  1  single-cycle request to force one frame; used only in change-only mode.
- `mux_a`  out  8  byte on the link; connects to CPLD `zxuno_a`.
- `clkmux`  out  1  link strobe; the CPLD latches on its rising edge.
- `selectmux`  out  1  1 = high byte, 0 = low byte.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  one-cycle pulse after the low-byte strobe has been sent.
- `sent_a`  out  16  last address fully delivered; mirrors the CPLD `bus_a`.

## Operation
- FSM states: IDLE, HI0, HI1, LO0, LO1. Each non-IDLE state lasts exactly `HALF_CYCLES` cycles.
- A 4-bit counter `cnt` counts 0..`HALF_CYCLES`-1 and resets to 0 on every state change.
- Registered outputs per state:
  - HI0: `selectmux`=1, `mux_a`=`snap[15:8]`, `clkmux`=0.
  - HI1: same as HI0 but `clkmux`=1.
  - LO0: `selectmux`=0, `mux_a`=`snap[7:0]`, `clkmux`=0.
  - LO1: same as LO0 but `clkmux`=1.
  - IDLE: `clkmux`=0; `selectmux` and `mux_a` hold their last values.
- Snapshot:
  - `snap` is loaded from `cpu_a` on the clock edge that enters HI0.
  - Both bytes of a frame always come from the same sample.
  - `cpu_a` changes during a frame do not alter that frame.
- End of LO1:
  - `sent_a` is loaded with `snap`.
  - `frame_done` pulses for one cycle.
  - The next state is chosen according to the mode (see Configuration).
- `busy` is 1 in HI0, HI1, LO0 and LO1, and 0 in IDLE.
- `flush` arriving while `busy`=1 sets the `pend` flag.
- `pend` is cleared on the edge that enters HI0.
- `flush` and frame end in the same cycle: `pend` is set and is consumed by the next frame.

## Timing
- Frame length is 4×`HALF_CYCLES` cycles. With `HALF_CYCLES`=1 a frame is 4 cycles.
- Data setup and hold around each `clkmux` rising edge is `HALF_CYCLES` cycles on each side; all outputs are registered and glitch-free.
- Reset values, asynchronous:
  - state = IDLE, `cnt`=0, `snap`=0.
  - `mux_a`=8'h00, `clkmux`=0, `selectmux`=0.
  - `busy`=0, `frame_done`=0, `sent_a`=16'h0000, `pend`=0.
- Reset asserted mid-frame aborts the frame immediately. `sent_a` returns to 0 even though the CPLD may still hold a partial address, and the first frame after reset rewrites it.
- Latency from the IDLE trigger cycle:
  - HI0 is entered on the next edge.
  - `frame_done` is asserted 4×`HALF_CYCLES`+1 cycles after the trigger.

## Configuration
- `ADDR_MUX_CHANGE_ONLY_EN` undefined (free-running mode):
  - IDLE exits unconditionally on the first cycle after reset.
  - At the end of LO1 the FSM goes directly to HI0 with a fresh snapshot, so frames run back-to-back.
  - `flush` and `pend` are ignored; `busy` is 0 only during the single post-reset IDLE cycle.
- `ADDR_MUX_CHANGE_ONLY_EN` defined (change-only mode):
  - IDLE → HI0 when `cpu_a` != `sent_a`, when `flush`=1, or when `pend`=1.
  - At the end of LO1 the FSM returns to IDLE.
  - After reset, an address of 16'h0000 sends no frame until `flush` is asserted.

## Test plan
- Free-running, `HALF_CYCLES`=1, `cpu_a`=16'hA55A held → `selectmux` pattern 1,1,0,0 repeating, `mux_a` A5,A5,5A,5A, `clkmux` 0,1,0,1, `frame_done` every 4 cycles, `sent_a`=16'hA55A after the first frame.
- Coherency: `cpu_a` changes 16'h1234→16'hFFFF during HI1 → that frame sends 12 then 34, `sent_a`=16'h1234; the next frame sends FF, FF.
- `HALF_CYCLES`=3 → each `clkmux` level lasts 3 cycles, frame length 12 cycles, `mux_a` stable for 3 cycles before and after every rising edge.
- Change-only mode: `cpu_a` held at 16'h0000 after reset → no `clkmux` edges; `cpu_a`←16'h4000 → exactly one frame (40, 00), then IDLE with `busy`=0.
- Change-only mode: `flush` pulsed during LO0 → the current frame completes, one extra identical frame follows, then IDLE.
- `rst` asserted during LO0 → `clkmux`=0, `selectmux`=0, `mux_a`=8'h00, `sent_a`=16'h0000 the same cycle; after release the next frame is complete and correct.
